spi_rx_capture: RTL and testbench

Receive-side stage of the SPI link, directly downstream of the SPI master: it watches `cs`, `miso` and a one-cycle SCLK rising-edge strobe, strips the command/address header bytes of each read frame, and assembles the returned data bytes into a sample word. The sample is handed to the consumer over a valid/ready handshake, with overrun and truncated-frame reporting. Everything runs in the 100 MHz system clock domain; no logic is clocked by SCLK.

---
 rtl/spi_rx_capture_pkg.sv | 22 ++
 rtl/spi_rx_capture_shift_in.sv | 39 +++
 rtl/spi_rx_capture.sv | 201 ++++++++++++++++++++
 tb/tb_spi_rx_capture.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_capture_pkg.sv
// Shared types and constants for the SPI receive-capture path.
package spi_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    DATA    = 2'd2,
    WAIT_CS = 2'd3
  } rx_state_t;

  localparam logic [7:0]  SPI_CMD_READ  = 8'h0B;
  localparam logic [7:0]  SPI_CMD_WRITE = 8'h0A;
  localparam int unsigned SPI_BYTE_BITS = 8;

  // Index of the last item in a run of 'count' items, as a 3-bit counter value.
  // A count of 0 wraps to 7; callers never compare against it in that case.
  function automatic logic [2:0] last_index(input int unsigned count);
    last_index = 3'(count - 32'd1);
  endfunction

endpackage

// File: rtl/spi_rx_capture_shift_in.sv
// 8-bit MSB-first deserializer. The completed byte and its done strobe are
// presented combinationally in the cycle that carries the 8th bit, so the
// consumer can act on it without an extra cycle of latency.
module spi_shift_in
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] byte_out,
  output logic       byte_done
);

  localparam logic [2:0] BIT_LAST = last_index(SPI_BYTE_BITS);

  // Only the first seven bits of a byte need storage; the eighth is din itself.
  logic [6:0] shift_r;
  logic [2:0] bit_cnt_r;

  // Shift in one bit per enable; clear drops any partial byte
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift_r   <= 7'd0;
      bit_cnt_r <= 3'd0;
    end else if (en) begin
      shift_r   <= {shift_r[5:0], din};
      bit_cnt_r <= bit_cnt_r + 3'd1;
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  assign byte_out  = {shift_r, din};
  assign byte_done = en && (bit_cnt_r == BIT_LAST);

endmodule

// File: rtl/spi_rx_capture.sv
// Receive-side capture for SPI read frames: skips the header bytes, assembles
// the data bytes into a sample and offers it on a valid/ready handshake with
// sticky overrun and a one-cycle truncated-frame pulse.
module spi_rx_capture
  import spi_pkg::*;
#(
  parameter int unsigned HDR_BYTES  = 2,
  parameter int unsigned DATA_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclk_rise,
  input  logic                    cs,
  input  logic                    miso,
  input  logic                    receive,
  output logic [8*DATA_BYTES-1:0] sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int unsigned DW        = 8 * DATA_BYTES;
  localparam logic [2:0]  HDR_LAST  = last_index(HDR_BYTES);
  localparam logic [2:0]  DATA_LAST = last_index(DATA_BYTES);
  localparam bit          NO_HDR    = (HDR_BYTES == 0);

  rx_state_t         state_r;
  rx_state_t         state_next_s;
  logic              cs_prev_r;
  logic              cs_fall_s;
  logic [2:0]        byte_cnt_r;
  logic [DW-1:0]     acc_r;
  logic [DW-1:0]     assembled_s;
  logic              in_frame_s;
  logic              shift_en_s;
  logic              shift_clr_s;
  logic              abort_s;
  logic              commit_s;
  logic              hdr_done_s;
  logic [7:0]        byte_s;
  logic              byte_done_s;
  logic [DW-1:0]     sample_data_r;
  logic              sample_valid_r;
  logic              overrun_r;
  logic              frame_err_r;
  logic              busy_r;

  spi_shift_in u_shift_in (
    .clk       (clk),
    .rst       (rst),
    .clr       (shift_clr_s),
    .en        (shift_en_s),
    .din       (miso),
    .byte_out  (byte_s),
    .byte_done (byte_done_s)
  );

  assign cs_fall_s   = !cs && cs_prev_r;
  // Previously accumulated bytes move up; the newest byte lands in the LSBs.
  assign assembled_s = (acc_r << SPI_BYTE_BITS) | DW'(byte_s);

  // Track the previous chip-select level for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_prev_r <= 1'b1;
    end else begin
      cs_prev_r <= cs;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a high cs inside a frame always wins over data
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          if (!receive) begin
            state_next_s = WAIT_CS;
          end else if (NO_HDR) begin
            state_next_s = DATA;
          end else begin
            state_next_s = HDR;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      HDR: begin
        if (cs) begin
          state_next_s = IDLE;
        end else if (hdr_done_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = HDR;
        end
      end
      DATA: begin
        if (cs) begin
          state_next_s = IDLE;
        end else if (commit_s) begin
          state_next_s = WAIT_CS;
        end else begin
          state_next_s = DATA;
        end
      end
      WAIT_CS: begin
        if (cs) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_CS;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: shifter control and abort detection
  always_comb begin
    in_frame_s  = (state_r == HDR) || (state_r == DATA);
    shift_en_s  = in_frame_s && sclk_rise && !cs;
    shift_clr_s = !in_frame_s;
    abort_s     = in_frame_s && cs;
  end

  // Byte-boundary events derived from the deserializer strobe
  always_comb begin
    hdr_done_s = (state_r == HDR)  && byte_done_s && (byte_cnt_r == HDR_LAST);
    commit_s   = (state_r == DATA) && byte_done_s && (byte_cnt_r == DATA_LAST);
  end

  // Byte counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r <= 3'd0;
    end else if (state_next_s != state_r) begin
      byte_cnt_r <= 3'd0;
    end else if (byte_done_s) begin
      byte_cnt_r <= byte_cnt_r + 3'd1;
    end else begin
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // Sample accumulator; emptied whenever no data phase is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {DW{1'b0}};
    end else if (state_r != DATA) begin
      acc_r <= {DW{1'b0}};
    end else if (byte_done_s) begin
      acc_r <= assembled_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Output register: commit/handshake, sticky overrun, error pulse, busy
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_data_r  <= {DW{1'b0}};
      sample_valid_r <= 1'b0;
      overrun_r      <= 1'b0;
      frame_err_r    <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      frame_err_r <= abort_s;
      busy_r      <= in_frame_s;
      if (commit_s) begin
        // A sample still held and not leaving this cycle is never overwritten.
        if (!sample_valid_r || sample_ready) begin
          sample_data_r  <= assembled_s;
          sample_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (sample_valid_r && sample_ready) begin
        sample_valid_r <= 1'b0;
      end else begin
        sample_valid_r <= sample_valid_r;
      end
    end
  end

  assign sample_data  = sample_data_r;
  assign sample_valid = sample_valid_r;
  assign overrun      = overrun_r;
  assign frame_err    = frame_err_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_spi_rx_capture.sv
// Self-checking bench for spi_rx_capture: a default instance (2 header bytes,
// 1 data byte) and a 2-data-byte instance sharing sclk/miso/receive/rst.
module tb_spi_rx_capture;
  import spi_pkg::*;

  logic        clk;
  logic        rst;
  logic        sclk_rise;
  logic        cs;
  logic        cs2;
  logic        miso;
  logic        receive;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        frame_err;
  logic        busy;
  logic [15:0] sample_data2;
  logic        sample_valid2;
  logic        sample_ready2;
  logic        overrun2;
  logic        frame_err2;
  logic        busy2;

  int checks = 0;
  int errors = 0;
  int valid_rises = 0;
  int ferr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp2_q[$];

  spi_rx_capture dut (
    .clk(clk), .rst(rst), .sclk_rise(sclk_rise), .cs(cs), .miso(miso),
    .receive(receive), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .frame_err(frame_err),
    .busy(busy)
  );

  spi_rx_capture #(.HDR_BYTES(2), .DATA_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .sclk_rise(sclk_rise), .cs(cs2), .miso(miso),
    .receive(receive), .sample_data(sample_data2), .sample_valid(sample_valid2),
    .sample_ready(sample_ready2), .overrun(overrun2), .frame_err(frame_err2),
    .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rcv;
    logic [23:0] frame;
    int          exp_samples;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and event counters, sampled mid-cycle
  task automatic monitor();
    if (!rst) begin
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb1_unexpected: got %0h expected none", sample_data);
        end else begin
          check("sb1_data", 32'(sample_data), 32'(exp_q.pop_front()));
        end
      end
      if (sample_valid2 && sample_ready2) begin
        if (exp2_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb2_unexpected: got %0h expected none", sample_data2);
        end else begin
          check("sb2_data", 32'(sample_data2), 32'(exp2_q.pop_front()));
        end
      end
      if (sample_valid && !prev_valid) valid_rises++;
      if (frame_err) ferr_cnt++;
    end
    prev_valid = sample_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic sclk_bit(input logic b);
    miso = b;
    sclk_rise = 1'b1;
    tick();
    sclk_rise = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] v, input int total, input int n);
    for (int i = 0; i < n; i++) sclk_bit(v[total-1-i]);
  endtask

  task automatic send_frame(input bit sel, input logic rcv, input logic [31:0] v, input int nbits);
    receive = rcv;
    if (sel) cs2 = 1'b0; else cs = 1'b0;
    tick(); tick();
    send_bits(v, nbits, nbits);
    if (sel) cs2 = 1'b1; else cs = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    int vr0;
    int fe0;
    logic [31:0] fr;

    vecs[0] = '{1'b1, {SPI_CMD_READ,  8'h08, 8'hA5}, 1, 8'hA5};
    vecs[1] = '{1'b0, {SPI_CMD_WRITE, 8'h2D, 8'h02}, 0, 8'h00};
    vecs[2] = '{1'b1, {SPI_CMD_READ,  8'h00, 8'h5A}, 1, 8'h5A};
    vecs[3] = '{1'b1, {SPI_CMD_READ,  8'hFF, 8'h00}, 1, 8'h00};
    vecs[4] = '{1'b1, {SPI_CMD_READ,  8'h3C, 8'hFF}, 1, 8'hFF};
    vecs[5] = '{1'b0, {SPI_CMD_WRITE, 8'h10, 8'hC3}, 0, 8'h00};

    rst = 1'b1; sclk_rise = 1'b0; cs = 1'b1; cs2 = 1'b1; miso = 1'b0;
    receive = 1'b0; sample_ready = 1'b1; sample_ready2 = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_data", 32'(sample_data), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid2", 32'(sample_valid2), 32'h0);

    // Latency and single-cycle valid on a default read frame
    fr = 32'h000B08A5;
    exp_q.push_back(8'hA5);
    receive = 1'b1; cs = 1'b0;
    tick(); tick();
    check("busy_hdr", 32'(busy), 32'h1);
    send_bits(fr, 24, 23);
    check("lat_valid_before", 32'(sample_valid), 32'h0);
    miso = fr[0]; sclk_rise = 1'b1;
    tick();
    check("lat_valid_rise", 32'(sample_valid), 32'h1);
    check("lat_data", 32'(sample_data), 32'hA5);
    sclk_rise = 1'b0;
    tick();
    check("lat_valid_fall", 32'(sample_valid), 32'h0);
    cs = 1'b1;
    tick(); tick(); tick();
    check("busy_idle", 32'(busy), 32'h0);

    // Table of complete frames with an always-ready consumer
    for (int k = 0; k < 6; k++) begin
      vr0 = valid_rises; fe0 = ferr_cnt;
      if (vecs[k].exp_samples != 0) exp_q.push_back(vecs[k].exp_data);
      send_frame(1'b0, vecs[k].rcv, 32'(vecs[k].frame), 24);
      check($sformatf("vec%0d_samples", k), 32'(valid_rises - vr0), 32'(vecs[k].exp_samples));
      check($sformatf("vec%0d_frame_err", k), 32'(ferr_cnt - fe0), 32'h0);
      check($sformatf("vec%0d_overrun", k), 32'(overrun), 32'h0);
      check($sformatf("vec%0d_drained", k), 32'(exp_q.size()), 32'h0);
    end

    // Overrun: second sample dropped while the first is held
    sample_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(1'b0, 1'b1, 32'h000B0811, 24);
    send_frame(1'b0, 1'b1, 32'h000B0822, 24);
    check("ovr_held_data", 32'(sample_data), 32'h11);
    check("ovr_held_valid", 32'(sample_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    sample_ready = 1'b1;
    tick();
    check("ovr_valid_fall", 32'(sample_valid), 32'h0);
    tick();
    check("ovr_valid_stays_low", 32'(sample_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Abort after 20 bits, then a clean frame
    vr0 = valid_rises; fe0 = ferr_cnt;
    receive = 1'b1; cs = 1'b0;
    tick(); tick();
    send_bits(32'h000B083C, 24, 20);
    cs = 1'b1;
    tick();
    check("abort_ferr_pulse", 32'(frame_err), 32'h1);
    tick();
    check("abort_ferr_end", 32'(frame_err), 32'h0);
    tick(); tick();
    check("abort_ferr_count", 32'(ferr_cnt - fe0), 32'h1);
    check("abort_no_valid", 32'(valid_rises - vr0), 32'h0);
    exp_q.push_back(8'h3C);
    send_frame(1'b0, 1'b1, 32'h000B083C, 24);
    check("after_abort_data", 32'(sample_data), 32'h3C);

    // cs rising together with the last data bit: bit ignored, frame aborted
    vr0 = valid_rises; fe0 = ferr_cnt;
    cs = 1'b0;
    tick(); tick();
    send_bits(32'h000B0877, 24, 23);
    cs = 1'b1; miso = 1'b1; sclk_rise = 1'b1;
    tick();
    sclk_rise = 1'b0;
    tick(); tick(); tick();
    check("race_ferr", 32'(ferr_cnt - fe0), 32'h1);
    check("race_no_valid", 32'(valid_rises - vr0), 32'h0);

    // Two data bytes, including a commit coinciding with a transfer
    exp2_q.push_back(16'h1234);
    send_frame(1'b1, 1'b1, 32'h0B081234, 32);
    check("d2_first", 32'(sample_data2), 32'h1234);
    sample_ready2 = 1'b0;
    exp2_q.push_back(16'h5678);
    send_frame(1'b1, 1'b1, 32'h0B085678, 32);
    check("d2_held_valid", 32'(sample_valid2), 32'h1);
    check("d2_held_data", 32'(sample_data2), 32'h5678);
    fr = 32'h0B08ABCD;
    exp2_q.push_back(16'hABCD);
    cs2 = 1'b0;
    tick(); tick();
    send_bits(fr, 32, 31);
    miso = fr[0]; sclk_rise = 1'b1; sample_ready2 = 1'b1;
    tick();
    check("d2_swap_valid", 32'(sample_valid2), 32'h1);
    check("d2_swap_data", 32'(sample_data2), 32'hABCD);
    check("d2_swap_overrun", 32'(overrun2), 32'h0);
    sclk_rise = 1'b0;
    tick();
    check("d2_swap_drained", 32'(sample_valid2), 32'h0);
    cs2 = 1'b1;
    tick(); tick();

    // Reset during DATA clears every output, then capture resumes
    sample_ready = 1'b0;
    send_frame(1'b0, 1'b1, 32'h000B0877, 24);
    check("pre_rst_data", 32'(sample_data), 32'h77);
    check("pre_rst_overrun", 32'(overrun), 32'h1);
    cs = 1'b0;
    tick(); tick();
    send_bits(32'h000B0899, 24, 20);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_data", 32'(sample_data), 32'h0);
    check("mid_rst_valid", 32'(sample_valid), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    rst = 1'b0; cs = 1'b1;
    tick(); tick();
    sample_ready = 1'b1;
    exp_q.push_back(8'h96);
    send_frame(1'b0, 1'b1, 32'h000B0896, 24);
    check("post_rst_data", 32'(sample_data), 32'h96);

    tick(); tick();
    check("sb1_empty", 32'(exp_q.size()), 32'h0);
    check("sb2_empty", 32'(exp2_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
